// File: rtl/uart_led_ctl_pkg.sv
// Shared types and constants for the UART LED controller: FSM states, LED modes,
// the frame sync byte and the command opcodes.
package uart_led_ctl_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GET_CMD  = 3'd1,
    S_GET_DATA = 3'd2,
    S_GET_CHK  = 3'd3,
    S_EXEC     = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_STATIC = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_ROTATE = 2'd3
  } mode_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] OP_OFF    = 8'h00;
  localparam logic [7:0] OP_SET    = 8'h01;
  localparam logic [7:0] OP_BLINK  = 8'h02;
  localparam logic [7:0] OP_ROTATE = 8'h03;

  function automatic logic cmd_valid(input logic [7:0] cmd);
    return cmd <= OP_ROTATE;
  endfunction

  function automatic mode_e cmd_to_mode(input logic [7:0] cmd);
    case (cmd)
      OP_OFF:    return MODE_OFF;
      OP_SET:    return MODE_STATIC;
      OP_BLINK:  return MODE_BLINK;
      OP_ROTATE: return MODE_ROTATE;
      default:   return MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/uart_led_ctl_led_pattern_gen.sv
// LED pattern engine: holds the current mode, the loaded DATA byte and the tick
// counter; steps blink/rotate patterns once every TICK_CYC cycles.
module led_pattern_gen
  import uart_led_ctl_pkg::*;
#(
  parameter int TICK_CYC = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [1:0] mode,
  input  logic [7:0] data,
  output logic [7:0] led
);

  localparam int TW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYC - 1);

  mode_e         mode_r;
  logic [TW-1:0] tick;
  logic [7:0]    base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r <= MODE_OFF;
      tick   <= '0;
      base   <= 8'h00;
      led    <= 8'h00;
    end else if (load) begin
      mode_r <= mode_e'(mode);
      tick   <= '0;
      base   <= data;
      led    <= (mode_e'(mode) == MODE_OFF) ? 8'h00 : data;
    end else if (tick == TICK_LAST) begin
      tick <= '0;
      // Blink toggles between base and zero by XOR-ing the base back in.
      case (mode_r)
        MODE_BLINK:  led <= led ^ base;
        MODE_ROTATE: led <= {led[6:0], led[7]};
        default:     led <= led;
      endcase
    end else begin
      tick <= tick + 1'b1;
    end
  end

endmodule

// File: rtl/uart_led_ctl.sv
// UART LED controller: parses SYNC/CMD/DATA[/CHK] frames and drives LED patterns.
// Define UART_LED_CTL_CHKSUM_EN to require the trailing CHK byte (CMD xor DATA).
module uart_led_ctl
  import uart_led_ctl_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 200_000_000,
  parameter int TIMEOUT_CYC = 2_000_000,
  parameter int TICK_CYC    = 50_000_000
) (
  input  logic       clk_rx,
  input  logic       rst_clk_rx_n,
  input  logic [7:0] rx_data,
  input  logic       rx_data_rdy,
  output logic [7:0] led_o,
  output logic       frm_err_o,
  output logic       busy_o,
  output logic [2:0] fsm_state
);

  // Handshake: rx_data is consumed in exactly the cycle rx_data_rdy is high;
  // there is no back-pressure, every strobe is evaluated by the FSM.

  if (CLK_FREQ_HZ < 1 || TIMEOUT_CYC < 2 || TICK_CYC < 1) begin : g_bad_cfg
    $error("uart_led_ctl: invalid parameter set");
  end

  localparam int TMW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMW-1:0] TIMER_LAST = TMW'(TIMEOUT_CYC - 1);

  state_e         state;
  logic [7:0]     cmd;
  logic [7:0]     data;
  logic [TMW-1:0] timer;
  logic           load;
  logic           timeout;

  assign timeout   = (timer == TIMER_LAST);
  assign fsm_state = state;

  always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
    if (!rst_clk_rx_n) begin
      state     <= S_IDLE;
      cmd       <= 8'h00;
      data      <= 8'h00;
      timer     <= '0;
      load      <= 1'b0;
      frm_err_o <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      load      <= 1'b0;
      frm_err_o <= 1'b0;
      // busy_o mirrors "in a GET_* state", so it also gates the timer.
      if (rx_data_rdy || !busy_o) timer <= '0;
      else                        timer <= timer + 1'b1;

      case (state)
        S_IDLE, S_EXEC: begin
          if (rx_data_rdy && rx_data == SYNC_BYTE) begin
            state  <= S_GET_CMD;
            busy_o <= 1'b1;
          end else begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
        end
        S_GET_CMD: begin
          if (rx_data_rdy) begin
            cmd   <= rx_data;
            state <= S_GET_DATA;
          end else if (timeout) begin
            state     <= S_IDLE;
            busy_o    <= 1'b0;
            frm_err_o <= 1'b1;
          end
        end
        S_GET_DATA: begin
          if (rx_data_rdy) begin
            data <= rx_data;
`ifdef UART_LED_CTL_CHKSUM_EN
            state <= S_GET_CHK;
`else
            busy_o <= 1'b0;
            if (cmd_valid(cmd)) begin
              state <= S_EXEC;
              load  <= 1'b1;
            end else begin
              state     <= S_IDLE;
              frm_err_o <= 1'b1;
            end
`endif
          end else if (timeout) begin
            state     <= S_IDLE;
            busy_o    <= 1'b0;
            frm_err_o <= 1'b1;
          end
        end
`ifdef UART_LED_CTL_CHKSUM_EN
        S_GET_CHK: begin
          if (rx_data_rdy) begin
            busy_o <= 1'b0;
            if (rx_data == (cmd ^ data) && cmd_valid(cmd)) begin
              state <= S_EXEC;
              load  <= 1'b1;
            end else begin
              state     <= S_IDLE;
              frm_err_o <= 1'b1;
            end
          end else if (timeout) begin
            state     <= S_IDLE;
            busy_o    <= 1'b0;
            frm_err_o <= 1'b1;
          end
        end
`endif
        default: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  led_pattern_gen #(
    .TICK_CYC(TICK_CYC)
  ) u_pattern (
    .clk  (clk_rx),
    .rst_n(rst_clk_rx_n),
    .load (load),
    .mode (cmd_to_mode(cmd)),
    .data (data),
    .led  (led_o)
  );

endmodule

// File: tb/tb_uart_led_ctl.sv
// Bench for uart_led_ctl: directed frames plus random traffic, checked every
// cycle against a frame-level model of the LED pattern, error pulses and busy.
module tb_uart_led_ctl;

  localparam int TICK = 4;
  localparam int TO   = 20;
`ifdef UART_LED_CTL_CHKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic [7:0] led_o;
  logic       frm_err_o;
  logic       busy_o;
  logic [2:0] fsm_state;

  uart_led_ctl #(
    .CLK_FREQ_HZ(1_000_000),
    .TIMEOUT_CYC(TO),
    .TICK_CYC   (TICK)
  ) dut (
    .clk_rx      (clk),
    .rst_clk_rx_n(rst_n),
    .rx_data     (rx_data),
    .rx_data_rdy (rx_rdy),
    .led_o       (led_o),
    .frm_err_o   (frm_err_o),
    .busy_o      (busy_o),
    .fsm_state   (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // model: active pattern, pending pattern, expected error-pulse cycles
  int         cur_mode = 0;
  logic [7:0] cur_d    = 8'h00;
  int         cur_t0   = 0;
  bit         pend_valid = 1'b0;
  int         pend_mode;
  logic [7:0] pend_d;
  int         pend_t0;
  bit         busy_exp = 1'b0;
  bit         mask     = 1'b0;
  logic [31:0] exp_q[$];

  function automatic logic [7:0] exp_led();
    int n;
    logic [15:0] w;
    n = (cyc - cur_t0) / TICK;
    case (cur_mode)
      0:       return 8'h00;
      1:       return cur_d;
      2:       return (n % 2 == 0) ? cur_d : 8'h00;
      default: begin
        w = {cur_d, cur_d} << (n % 8);
        return w[15:8];
      end
    endcase
  endfunction

  // scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    bit e;
    if (pend_valid && cyc >= pend_t0) begin
      cur_mode   = pend_mode;
      cur_d      = pend_d;
      cur_t0     = pend_t0;
      pend_valid = 1'b0;
    end
    check("led", led_o, exp_led());
    if (!mask) begin
      e = (exp_q.size() > 0) && (exp_q[0] == cyc);
      if (e) void'(exp_q.pop_front());
      check("frm_err", frm_err_o, e);
      check("busy", busy_o, busy_exp);
    end
  end

  // driver tasks; all start and end 1 time unit after a rising edge
  task automatic send_byte(input logic [7:0] b);
    rx_rdy  = 1'b1;
    rx_data = b;
    @(posedge clk); #1;
    rx_rdy  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] d, input bit bad,
                            input bit rnd, output int t0);
    bit ok;
    logic [7:0] chk;
    chk = bad ? (c ^ d ^ (8'h01 << $urandom_range(0, 7))) : (c ^ d);
    ok  = (c < 8'h04) && (CHK_EN ? !bad : 1'b1);
    send_byte(8'hA5);
    busy_exp = 1'b1;
    if (rnd) idle($urandom_range(0, 3));
    send_byte(c);
    if (rnd) idle($urandom_range(0, 3));
    send_byte(d);
    if (CHK_EN) begin
      if (rnd) idle($urandom_range(0, 3));
      send_byte(chk);
    end
    busy_exp = 1'b0;
    if (ok) begin
      pend_mode  = int'(c);
      pend_d     = d;
      pend_t0    = cyc + 1;
      pend_valid = 1'b1;
      t0         = cyc + 1;
    end else begin
      exp_q.push_back(cyc);
      t0 = -1;
    end
  endtask

  task automatic sample_at(input int t, input logic [7:0] v, input string tag);
    do @(negedge clk); while (cyc < t);
    check(tag, led_o, v);
    @(posedge clk); #1;
  endtask

  initial begin
    int t0;
    int pulses;
    rst_n   = 1'b0;
    rx_rdy  = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_led", led_o, 8'h00);
    check("rst_err", frm_err_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    rst_n = 1'b1;

    // SET 3C, with a non-sync byte first that must be ignored
    send_byte(8'h3C);
    idle(2);
    send_frame(8'h01, 8'h3C, 1'b0, 1'b0, t0);
    sample_at(t0, 8'h3C, "set_3c");
    idle(3);

    // BLINK F0
    send_frame(8'h02, 8'hF0, 1'b0, 1'b0, t0);
    sample_at(t0, 8'hF0, "blink_0");
    sample_at(t0 + 3, 8'hF0, "blink_0_hold");
    sample_at(t0 + 4, 8'h00, "blink_1");
    sample_at(t0 + 8, 8'hF0, "blink_2");
    sample_at(t0 + 12, 8'h00, "blink_3");

    // ROTATE 81 then a rejected frame that must not disturb it
    send_frame(8'h03, 8'h81, 1'b0, 1'b0, t0);
    sample_at(t0, 8'h81, "rot_0");
    sample_at(t0 + 4, 8'h03, "rot_1");
    sample_at(t0 + 8, 8'h06, "rot_2");
    sample_at(t0 + 12, 8'h0C, "rot_3");
    if (CHK_EN) send_frame(8'h01, 8'h55, 1'b1, 1'b0, t0);
    else        send_frame(8'h09, 8'h00, 1'b0, 1'b0, t0);
    check("reject_t0", t0, -1);
    idle(12);

    // inter-byte timeout
    send_byte(8'hA5);
    busy_exp = 1'b1;
    send_byte(8'h01);
    mask   = 1'b1;
    pulses = 0;
    repeat (TO + 4) begin
      @(negedge clk);
      if (frm_err_o === 1'b1) pulses++;
    end
    busy_exp = 1'b0;
    check("to_pulses", pulses, 1);
    check("to_busy", busy_o, 1'b0);
    @(posedge clk); #1;
    mask = 1'b0;
    idle(2);

    // reset mid-frame
    send_byte(8'hA5);
    busy_exp = 1'b1;
    send_byte(8'h01);
    rst_n      = 1'b0;
    cur_mode   = 0;
    pend_valid = 1'b0;
    busy_exp   = 1'b0;
    #1;
    check("mid_rst_led", led_o, 8'h00);
    check("mid_rst_busy", busy_o, 1'b0);
    check("mid_rst_err", frm_err_o, 1'b0);
    check("mid_rst_state", fsm_state, 3'd0);
    idle(2);
    rst_n = 1'b1;
    send_frame(8'h01, 8'h11, 1'b0, 1'b0, t0);
    sample_at(t0, 8'h11, "post_rst_set");

    // random traffic, including back-to-back frames (sync during EXEC)
    for (int i = 0; i < 60; i++) begin
      logic [7:0] junk;
      if ($urandom_range(0, 3) == 0) begin
        junk = 8'($urandom_range(0, 255));
        if (junk == 8'hA5) junk = 8'h5A;
        send_byte(junk);
      end
      send_frame(8'($urandom_range(0, 5)), 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 3) == 0), 1'b1, t0);
      idle($urandom_range(0, 12));
    end
    idle(10);

    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_led_ctl.md
UART_LED_CTL -- requirements
Module: uart_led_ctl

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 200_000_000, input clock frequency.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 2_000_000, maximum cycles allowed between bytes inside a frame.
REQ-003 SHALL have parameter TICK_CYC, default 50_000_000, pattern step period in cycles.
REQ-004 SHALL have port clk_rx  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_clk_rx_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port rx_data  input  8  received byte from the UART receiver.
REQ-007 SHALL have port rx_data_rdy  input  1  one-cycle strobe; rx_data valid this cycle.
REQ-008 SHALL have port led_o  output  8  LED drive, registered.
REQ-009 SHALL have port frm_err_o  output  1  one-cycle pulse on a rejected frame.
REQ-010 SHALL have port busy_o  output  1  high while a frame is partially received.

Function
REQ-011 Frame SHALL be SYNC(0xA5), CMD, DATA, CHK; CHK = CMD xor DATA.
REQ-012 FSM states SHALL be IDLE, GET_CMD, GET_DATA, GET_CHK, EXEC.
REQ-013 IDLE: a strobe with 0xA5 -> GET_CMD; any other byte SHALL be ignored, no error.
REQ-014 GET_CMD -> GET_DATA -> GET_CHK, each on a strobe; CMD and DATA latched on their strobes.
REQ-015 GET_CHK: CHK match and CMD valid -> EXEC; otherwise -> IDLE with frm_err_o pulse the next cycle.
REQ-016 EXEC SHALL last exactly one cycle, then -> IDLE; the new mode/pattern SHALL be visible on led_o on the cycle after EXEC.
REQ-017 A strobe arriving during EXEC SHALL be evaluated as in IDLE (0xA5 -> GET_CMD).
REQ-018 CMD 0x00 OFF: led_o = 0x00, static.
REQ-019 CMD 0x01 SET: led_o = DATA, static.
REQ-020 CMD 0x02 BLINK: led_o alternates DATA / 0x00 every TICK_CYC cycles, starting with DATA.
REQ-021 CMD 0x03 ROTATE: led_o starts at DATA, rotates left by 1 every TICK_CYC cycles; bit7 wraps to bit0.
REQ-022 CMD 0x04..0xFF SHALL be invalid (error per REQ-015); the current mode is unchanged.
REQ-023 The tick counter SHALL count 0..TICK_CYC-1, wrap to 0, and be cleared on every EXEC.
REQ-024 The inter-byte timer SHALL clear on every strobe and count only in the GET_* states; reaching TIMEOUT_CYC-1 -> IDLE with a frm_err_o pulse.
REQ-025 Strobe and timeout in the same cycle: the strobe SHALL win.
REQ-026 busy_o SHALL be 1 exactly in GET_CMD, GET_DATA and GET_CHK.
REQ-027 A rejected frame SHALL NOT alter led_o or the running pattern.

Reset
REQ-028 Reset asserted SHALL immediately force IDLE, led_o=0x00, mode OFF, frm_err_o=0, busy_o=0, and all counters to 0.
REQ-029 Reset mid-frame SHALL discard the partial frame with no error pulse.
REQ-030 Deassertion is assumed synchronized externally; the first strobe after release SHALL be accepted.

Configuration
REQ-031 Macro UART_LED_CTL_CHKSUM_EN defined: frame per REQ-011, GET_CHK present.
REQ-032 Macro UART_LED_CTL_CHKSUM_EN undefined: GET_CHK removed; 3-byte frame; GET_DATA -> EXEC (valid CMD) or -> IDLE plus error (invalid CMD).

Structure
REQ-033 Package uart_led_ctl_pkg SHALL hold the state enum, SYNC_BYTE=0xA5, opcode constants and the mode enum (OFF/STATIC/BLINK/ROTATE).
REQ-034 Sub-module led_pattern_gen SHALL own the tick counter and pattern register; inputs are load strobe, mode and DATA; output is led_o.

Verification
REQ-035 Send A5 01 3C 3D -> led_o=0x3C two cycles after the last strobe; frm_err_o stays 0.
REQ-036 Send A5 02 F0 F2, TICK_CYC=4 -> led_o sequence F0,00,F0,00, changing every 4 cycles.
REQ-037 Send A5 03 81 82, TICK_CYC=4 -> led_o sequence 81,03,06,0C; afterwards A5 01 55 00 (bad CHK) -> one frm_err_o pulse and the rotation continues.
REQ-038 Send A5 01, then idle TIMEOUT_CYC cycles -> one frm_err_o pulse, busy_o falls, led_o unchanged.
REQ-039 Assert rst_clk_rx_n low after A5 01 -> immediate IDLE, led_o=0x00, no error; a subsequent A5 01 11 10 -> led_o=0x11.
REQ-040 Build without UART_LED_CTL_CHKSUM_EN, send A5 01 77 -> led_o=0x77; send A5 09 00 -> frm_err_o pulse.
